// File: rtl/count_ctrl_gen_pkg.sv
// rtl/count_ctrl_gen_pkg.sv - control codes and FSM states shared by the counter command generator
package count_ctrl_gen_pkg;

  localparam logic [1:0] CTRL_HOLD = 2'b00;
  localparam logic [1:0] CTRL_UP   = 2'b01;
  localparam logic [1:0] CTRL_DOWN = 2'b10;
  localparam logic [1:0] CTRL_CLR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_UP_RUN   = 2'd1,
    ST_DOWN_RUN = 2'd2,
    ST_CLR_WAIT = 2'd3
  } state_t;

  // A step that would cross a bound degrades to hold but still uses its slot.
  function automatic logic [1:0] step_code(input logic up, input logic allowed);
    if (!allowed) return CTRL_HOLD;
    return up ? CTRL_UP : CTRL_DOWN;
  endfunction

endpackage

// File: rtl/count_ctrl_gen_repeat_timer.sv
// rtl/count_ctrl_gen_repeat_timer.sv - terminal-count divider for button auto-repeat
module count_ctrl_gen_repeat_timer #(
  parameter int DIV = 4,
  parameter int TW  = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [TW-1:0] LAST = TW'(DIV - 1);

  logic [TW-1:0] count;

  // tick marks the enabled cycle on which the count wraps back to zero
  assign tick = (count == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/count_ctrl_gen.sv
// rtl/count_ctrl_gen.sv - button-to-counter command generator with auto-repeat and bound clamping
module count_ctrl_gen
  import count_ctrl_gen_pkg::*;
#(
  parameter int W        = 4,
  parameter int MIN      = 0,
  parameter int MAX      = (1 << W) - 1,
  parameter int STEP_DIV = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_clr,
  output logic [1:0]   ctrl,
  output logic [W-1:0] shadow,
  output logic         at_max,
  output logic         at_min
);

  localparam logic [W-1:0] MIN_V = W'(MIN);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  state_t       state;
  logic [W-1:0] proj;
  logic         up_ok;
  logic         down_ok;
  logic         only_up;
  logic         only_down;
  logic         keep_run;
  logic         tick;

  // proj is what the counter will hold after the pulse currently on ctrl lands
  always_comb begin
    proj = shadow;
    case (ctrl)
      CTRL_UP:   proj = shadow + 1'b1;
      CTRL_DOWN: proj = shadow - 1'b1;
      CTRL_CLR:  proj = '0;
      default:   proj = shadow;
    endcase
  end

  assign up_ok     = (proj < MAX_V);
  assign down_ok   = (proj > MIN_V);
  assign only_up   = btn_up & ~btn_down;
  assign only_down = btn_down & ~btn_up;
  assign keep_run  = ~btn_clr & (((state == ST_UP_RUN) & only_up) |
                                 ((state == ST_DOWN_RUN) & only_down));

  count_ctrl_gen_repeat_timer #(
    .DIV (STEP_DIV)
  ) u_repeat_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (~keep_run),
    .en    (keep_run),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      ctrl   <= CTRL_CLR;
      shadow <= '0;
    end else begin
      shadow <= proj;
      case (state)
        ST_IDLE: begin
          if (btn_clr) begin
            ctrl  <= CTRL_CLR;
            state <= ST_CLR_WAIT;
          end else if (only_up) begin
            ctrl  <= step_code(1'b1, up_ok);
            state <= ST_UP_RUN;
          end else if (only_down) begin
            ctrl  <= step_code(1'b0, down_ok);
            state <= ST_DOWN_RUN;
          end else begin
            ctrl  <= CTRL_HOLD;
          end
        end
        ST_UP_RUN: begin
          if (btn_clr) begin
            ctrl  <= CTRL_CLR;
            state <= ST_CLR_WAIT;
          end else if (!only_up) begin
            ctrl  <= CTRL_HOLD;
            state <= ST_IDLE;
          end else begin
            ctrl  <= tick ? step_code(1'b1, up_ok) : CTRL_HOLD;
          end
        end
        ST_DOWN_RUN: begin
          if (btn_clr) begin
            ctrl  <= CTRL_CLR;
            state <= ST_CLR_WAIT;
          end else if (!only_down) begin
            ctrl  <= CTRL_HOLD;
            state <= ST_IDLE;
          end else begin
            ctrl  <= tick ? step_code(1'b0, down_ok) : CTRL_HOLD;
          end
        end
        ST_CLR_WAIT: begin
          // one clear per press: wait for release before accepting anything
          ctrl <= CTRL_HOLD;
          if (!btn_clr) state <= ST_IDLE;
        end
        default: begin
          ctrl  <= CTRL_HOLD;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign at_max = (shadow == MAX_V);
  assign at_min = (shadow == MIN_V);

endmodule

// File: tb/tb_count_ctrl_gen.sv
// tb/tb_count_ctrl_gen.sv - randomized and directed self-checking bench for count_ctrl_gen
module tb_count_ctrl_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_clr = 1'b0;
  logic [1:0] ctrl_a, ctrl_b;
  logic [3:0] shadow_a, shadow_b;
  logic       at_max_a, at_min_a, at_max_b, at_min_b;

  int checks = 0;
  int errors = 0;

  int p_min[2] = '{0, 2};
  int p_max[2] = '{15, 5};
  int p_div[2] = '{4, 3};

  int m_ctrl[2]   = '{0, 0};
  int m_shadow[2] = '{0, 0};
  int m_dir[2]    = '{0, 0};
  int m_age[2]    = '{0, 0};
  bit m_clrw[2]   = '{1'b0, 1'b0};

  int n_up, n_dn, n_clr, n_b;

  always #5 clk = ~clk;

  count_ctrl_gen dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_clr  (btn_clr),
    .ctrl     (ctrl_a),
    .shadow   (shadow_a),
    .at_max   (at_max_a),
    .at_min   (at_min_a)
  );

  count_ctrl_gen #(.W(4), .MIN(2), .MAX(5), .STEP_DIV(3)) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_clr  (btn_clr),
    .ctrl     (ctrl_b),
    .shadow   (shadow_b),
    .at_max   (at_max_b),
    .at_min   (at_min_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int apply(input int v, input int c);
    case (c)
      1:       return (v + 1) % 16;
      2:       return (v + 15) % 16;
      3:       return 0;
      default: return v;
    endcase
  endfunction

  function automatic int want(input int i, input int dir, input int proj);
    if (dir == 1) return (proj >= p_max[i]) ? 0 : 1;
    return (proj <= p_min[i]) ? 0 : 2;
  endfunction

  // Behavioural rule set: a held direction pulses on every multiple of STEP_DIV
  // cycles since the press, clears fire once per press, both-pressed holds.
  task automatic model_edge(input int i);
    int proj;
    int nc;
    bit alone;
    if (!rst_n) begin
      m_ctrl[i] = 3; m_shadow[i] = 0; m_dir[i] = 0; m_age[i] = 0; m_clrw[i] = 1'b0;
      return;
    end
    proj = apply(m_shadow[i], m_ctrl[i]);
    m_shadow[i] = proj;
    nc = 0;
    if (m_clrw[i]) begin
      m_clrw[i] = btn_clr;
    end else if (btn_clr) begin
      nc = 3; m_clrw[i] = 1'b1; m_dir[i] = 0;
    end else if (m_dir[i] != 0) begin
      alone = (m_dir[i] == 1) ? (btn_up && !btn_down) : (btn_down && !btn_up);
      if (alone) begin
        m_age[i]++;
        if (m_age[i] % p_div[i] == 0) nc = want(i, m_dir[i], proj);
      end else begin
        m_dir[i] = 0;
      end
    end else if (btn_up != btn_down) begin
      m_dir[i] = btn_up ? 1 : 2;
      m_age[i] = 0;
      nc = want(i, m_dir[i], proj);
    end
    m_ctrl[i] = nc;
  endtask

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i);
    #1;
    check("ctrl_a", ctrl_a, m_ctrl[0]);
    check("shadow_a", shadow_a, m_shadow[0]);
    check("at_max_a", at_max_a, m_shadow[0] == p_max[0]);
    check("at_min_a", at_min_a, m_shadow[0] == p_min[0]);
    check("ctrl_b", ctrl_b, m_ctrl[1]);
    check("shadow_b", shadow_b, m_shadow[1]);
    check("at_max_b", at_max_b, m_shadow[1] == p_max[1]);
    check("at_min_b", at_min_b, m_shadow[1] == p_min[1]);
    if (ctrl_a == 2'b01) n_up++;
    if (ctrl_a == 2'b10) n_dn++;
    if (ctrl_a == 2'b11) n_clr++;
    if (ctrl_b != 2'b00) n_b++;
  endtask

  task automatic hold(input bit u, input bit d, input bit c, input int n);
    btn_up = u; btn_down = d; btn_clr = c;
    repeat (n) step();
  endtask

  task automatic clear_counts();
    n_up = 0; n_dn = 0; n_clr = 0; n_b = 0;
  endtask

  initial begin
    clear_counts();

    rst_n = 1'b0;
    hold(0, 0, 0, 3);
    check("rst_ctrl", ctrl_a, 3);
    check("rst_shadow", shadow_a, 0);
    check("rst_at_min_a", at_min_a, 1);
    check("rst_at_max_a", at_max_a, 0);
    check("rst_at_min_b", at_min_b, 0);
    rst_n = 1'b1;
    hold(0, 0, 0, 1);
    check("post_rst_ctrl", ctrl_a, 0);
    check("post_rst_shadow", shadow_a, 0);

    clear_counts();
    hold(1, 0, 0, 9);
    hold(0, 0, 0, 1);
    check("hold_up_pulses", n_up, 3);
    check("hold_up_shadow", shadow_a, 3);

    clear_counts();
    hold(0, 1, 0, 9);
    hold(0, 0, 0, 1);
    check("hold_dn_pulses", n_dn, 3);
    check("hold_dn_shadow", shadow_a, 0);
    check("hold_dn_at_min", at_min_a, 1);

    clear_counts();
    hold(1, 0, 0, 1);
    hold(0, 0, 0, 1);
    check("tap_pulses", n_up, 1);
    check("tap_shadow", shadow_a, 1);
    check("tap_shadow_b", shadow_b, 3);

    clear_counts();
    hold(1, 0, 0, 70);
    hold(0, 0, 0, 2);
    check("sat_up_pulses", n_up, 14);
    check("sat_up_shadow", shadow_a, 15);
    check("sat_up_at_max", at_max_a, 1);
    check("sat_b_pulses", n_b, 2);
    check("sat_b_shadow", shadow_b, 5);

    clear_counts();
    hold(0, 1, 0, 30);
    hold(0, 0, 0, 2);
    check("sat_dn_b_pulses", n_b, 3);
    check("sat_dn_b_shadow", shadow_b, 2);
    check("sat_dn_b_at_min", at_min_b, 1);
    check("sat_dn_a_shadow", shadow_a, 7);

    hold(1, 0, 0, 2);
    clear_counts();
    hold(1, 0, 1, 5);
    check("clr_once", n_clr, 1);
    check("clr_no_up", n_up, 0);
    check("clr_shadow", shadow_a, 0);
    hold(0, 0, 0, 1);
    hold(0, 0, 1, 1);
    check("clr_repress", n_clr, 2);
    hold(0, 0, 0, 1);

    clear_counts();
    hold(1, 1, 0, 10);
    check("both_hold_a", n_up + n_dn + n_clr, 0);
    check("both_hold_b", n_b, 0);

    hold(1, 0, 0, 12);
    hold(0, 1, 0, 3);
    rst_n = 1'b0;
    hold(0, 1, 0, 1);
    check("midrun_rst_ctrl", ctrl_a, 3);
    check("midrun_rst_shadow", shadow_a, 0);
    rst_n = 1'b1;
    hold(0, 1, 0, 1);
    check("midrun_rel_ctrl", ctrl_a, 0);
    hold(0, 0, 0, 1);

    for (int seg = 0; seg < 200; seg++) begin
      rst_n = ($urandom_range(0, 24) != 0);
      hold($urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 7) == 0),
           rst_n ? $urandom_range(1, 14) : $urandom_range(1, 2));
    end
    rst_n = 1'b1;
    hold(0, 0, 0, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
